// File: rtl/mmio_responder.sv
// -----------------------------------------------------------------------------
// mmio_responder
//   I/O-window responder for the RISC machine's mem_cmd/mem_addr/write_data bus.
//   It owns every address with mem_addr[8]=1. Reads return the synchronized
//   switches, a free-running cycle counter or the LED register. Writes update
//   the LED register. Each owned request completes with a one-cycle mem_ready
//   pulse after LATENCY wait cycles. Owned addresses that map to nothing are
//   still acknowledged, and they set the sticky addr_err flag.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   mem_cmd     2'b00 none, 2'b01 read, 2'b10 write, 2'b11 none
//   mem_addr    9-bit request address
//   write_data  16-bit write payload (LED uses bits [7:0])
//   sw          raw asynchronous switch inputs
//   read_data   read response, zero outside the response cycle
//   mem_ready   one-cycle completion pulse
//   led         LED register
//   addr_err    sticky unmapped-address flag
// -----------------------------------------------------------------------------
module mmio_responder #(
  parameter int unsigned LATENCY  = 1,
  parameter logic [8:0]  LED_ADDR = 9'h100,
  parameter logic [8:0]  SW_ADDR  = 9'h140,
  parameter logic [8:0]  CNT_ADDR = 9'h141
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  input  logic [7:0]  sw,
  output logic [15:0] read_data,
  output logic        mem_ready,
  output logic [7:0]  led,
  output logic        addr_err
);

  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  // The WAIT down-counter counts LATENCY-1 down to 0. With LATENCY=0 it is never used.
  localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  wait_cnt;
  logic [15:0] cnt;
  logic [7:0]  sw_meta, sw_sync;
  logic        is_write_q;
  logic [8:0]  addr_q;
  logic [7:0]  wdata_q;
  logic [15:0] rdata_q;

  logic        accept;
  logic        unmapped;
  logic [15:0] src;

  // Only the LED byte of the write payload is ever stored.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^write_data[15:8];

  assign accept = (state == S_IDLE) && mem_addr[8] &&
                  ((mem_cmd == MREAD) || (mem_cmd == MWRITE));

  // Read source selection. The value is sampled at the capture edge.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    src      = '0;
    unmapped = 1'b0;
    if (mem_addr == SW_ADDR)       src = {8'h00, sw_sync};
    else if (mem_addr == CNT_ADDR) src = cnt;
    else if (mem_addr == LED_ADDR) src = {8'h00, led};
    else                           unmapped = 1'b1;
  end

  // State register
  // NOTE: sequential state uses non-blocking assignments. That way every flop
  // samples the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic. Bus inputs matter only in IDLE, so a command held
  // through RESP is captured no earlier than the next IDLE cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = (LATENCY > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (wait_cnt == 4'd0) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Synchronizer, counter, capture registers and the LED register.
  // NOTE: all of these are plain flops with an explicit reset value. There is
  // no memory array here, so resetting every flop is cheap and keeps the
  // power-up state deterministic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta    <= '0;
      sw_sync    <= '0;
      cnt        <= '0;
      wait_cnt   <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      led        <= '0;
      addr_err   <= 1'b0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      cnt     <= cnt + 16'd1;

      if (accept) begin
        is_write_q <= (mem_cmd == MWRITE);
        addr_q     <= mem_addr;
        wdata_q    <= write_data[7:0];
        rdata_q    <= (mem_cmd == MREAD) ? src : 16'h0000;
        wait_cnt   <= WAIT_LOAD;
        if (unmapped) addr_err <= 1'b1;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      // The LED commits on the edge that leaves RESP. A reset during WAIT
      // therefore drops the write.
      if ((state == S_RESP) && is_write_q && (addr_q == LED_ADDR))
        led <= wdata_q;
    end
  end

  assign mem_ready = (state == S_RESP);
  assign read_data = mem_ready ? rdata_q : 16'h0000;

endmodule
